// File: rtl/counter_updown_mod.sv
// WIDTH-bit synchronous up/down counter with programmable modulus, wrap/saturate
// boundary handling, a registered terminal-event pulse and a sticky overflow flag.
module counter_updown_mod #(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             enable,
  input  logic             up_down,
  input  logic             saturate,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             tc_pulse,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_count_next;
  logic             w_tc_next;
  logic             w_ovf_next;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_val;

  assign w_at_max  = (r_count == MAX_VAL);
  assign w_at_zero = (r_count == '0);

  // Out-of-range load values clamp so count can never exceed MAX_VAL.
  assign w_load_val = (load_data > MAX_VAL) ? MAX_VAL : load_data;

  always_comb begin
    w_count_next = r_count;
    w_tc_next    = 1'b0;
    w_ovf_next   = r_ovf;
    if (clear) begin
      w_count_next = '0;
      w_ovf_next   = 1'b0;
    end else if (load) begin
      w_count_next = w_load_val;
    end else if (enable) begin
      if (up_down) begin
        if (w_at_max) begin
          w_tc_next    = 1'b1;
          w_ovf_next   = 1'b1;
          w_count_next = saturate ? MAX_VAL : '0;
        end else begin
          w_count_next = r_count + ONE;
        end
      end else begin
        if (w_at_zero) begin
          w_tc_next    = 1'b1;
          w_ovf_next   = 1'b1;
          w_count_next = saturate ? '0 : MAX_VAL;
        end else begin
          w_count_next = r_count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tc    <= w_tc_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign count    = r_count;
  assign at_max   = w_at_max;
  assign at_zero  = w_at_zero;
  assign tc_pulse = r_tc;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed self-checking bench: mod-10, full-range 8-bit and MAX_VAL=1 counters
// driven from one shared stimulus set.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       reset, clear, load, enable, up_down, saturate;
  logic [7:0] load_data;

  logic [3:0] c4;  logic m4, z4, t4, o4;
  logic [7:0] c8;  logic m8, z8, t8, o8;
  logic [0:0] c1;  logic m1, z1, t1, o1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(4'd9)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_data(load_data[3:0]),
    .enable(enable), .up_down(up_down), .saturate(saturate),
    .count(c4), .at_max(m4), .at_zero(z4), .tc_pulse(t4), .overflow(o4));

  counter_updown_mod #(.WIDTH(8), .MAX_VAL(8'd255)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_data(load_data),
    .enable(enable), .up_down(up_down), .saturate(saturate),
    .count(c8), .at_max(m8), .at_zero(z8), .tc_pulse(t8), .overflow(o8));

  counter_updown_mod #(.WIDTH(1), .MAX_VAL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_data(load_data[0:0]),
    .enable(enable), .up_down(up_down), .saturate(saturate),
    .count(c1), .at_max(m1), .at_zero(z1), .tc_pulse(t1), .overflow(o1));

  task automatic idle();
    reset = 0; clear = 0; load = 0; enable = 0; up_down = 1; saturate = 0; load_data = 8'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; step(); idle();
    n_checks++;
    if (c4 !== 4'd0 || t4 !== 1'b0 || o4 !== 1'b0 || z4 !== 1'b1 || m4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: count=%0d tc=%b ovf=%b zero=%b max=%b want 0 0 0 1 0", c4, t4, o4, z4, m4);
    end
    enable = 1; up_down = 1;
    repeat (5) step();
    n_checks++;
    if (c4 !== 4'd5) begin n_fail++; $display("FAIL count_to_5: count=%0d want 5", c4); end
    reset = 1; load = 1; load_data = 8'd7; step(); idle();
    n_checks++;
    if (c4 !== 4'd0 || t4 !== 1'b0 || o4 !== 1'b0 || z4 !== 1'b1) begin
      n_fail++; $display("FAIL reset_override: count=%0d tc=%b ovf=%b zero=%b want 0 0 0 1", c4, t4, o4, z4);
    end
    $display("test_reset done");
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_c;
    idle(); enable = 1; up_down = 1; saturate = 0;
    for (int i = 0; i < 12; i++) begin
      exp_c = 4'((i + 1) % 10);
      step();
      n_checks++;
      if (c4 !== exp_c || t4 !== (exp_c == 4'd0)) begin
        n_fail++; $display("FAIL up_wrap[%0d]: count=%0d tc=%b want %0d %b", i, c4, t4, exp_c, exp_c == 4'd0);
      end
    end
    n_checks++;
    if (o4 !== 1'b1) begin n_fail++; $display("FAIL up_wrap_ovf: ovf=%b want 1", o4); end
    $display("test_up_wrap done");
  endtask

  task automatic test_down_saturate();
    logic [3:0] exp_c [5];
    logic       exp_t [5];
    exp_c = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idle(); clear = 1; load = 1; load_data = 8'd6; enable = 1; step(); idle();
    n_checks++;
    if (c4 !== 4'd0 || o4 !== 1'b0 || t4 !== 1'b0) begin
      n_fail++; $display("FAIL clear: count=%0d ovf=%b tc=%b want 0 0 0", c4, o4, t4);
    end
    load = 1; load_data = 8'd2; step(); idle();
    n_checks++;
    if (c4 !== 4'd2) begin n_fail++; $display("FAIL load2: count=%0d want 2", c4); end
    enable = 1; up_down = 0; saturate = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (c4 !== exp_c[i] || t4 !== exp_t[i]) begin
        n_fail++; $display("FAIL down_sat[%0d]: count=%0d tc=%b want %0d %b", i, c4, t4, exp_c[i], exp_t[i]);
      end
    end
    n_checks++;
    if (o4 !== 1'b1 || z4 !== 1'b1) begin n_fail++; $display("FAIL down_sat_ovf: ovf=%b zero=%b want 1 1", o4, z4); end
    $display("test_down_saturate done");
  endtask

  task automatic test_load_clamp();
    idle(); load = 1; load_data = 8'd13; enable = 1; up_down = 1; step(); idle();
    n_checks++;
    if (c4 !== 4'd9 || m4 !== 1'b1 || t4 !== 1'b0 || o4 !== 1'b1) begin
      n_fail++; $display("FAIL load_clamp: count=%0d max=%b tc=%b ovf=%b want 9 1 0 1", c4, m4, t4, o4);
    end
    enable = 1; up_down = 1; saturate = 1; step(); idle();
    n_checks++;
    if (c4 !== 4'd9 || t4 !== 1'b1) begin
      n_fail++; $display("FAIL up_saturate: count=%0d tc=%b want 9 1", c4, t4);
    end
    clear = 1; load = 1; load_data = 8'd4; step(); idle();
    n_checks++;
    if (c4 !== 4'd0 || o4 !== 1'b0 || t4 !== 1'b0) begin
      n_fail++; $display("FAIL clear_over_load: count=%0d ovf=%b tc=%b want 0 0 0", c4, o4, t4);
    end
    $display("test_load_clamp done");
  endtask

  task automatic test_direction();
    idle(); load = 1; load_data = 8'd9; step(); idle();
    enable = 1; up_down = 0; step();
    n_checks++;
    if (c4 !== 4'd8 || t4 !== 1'b0) begin n_fail++; $display("FAIL dir_down: count=%0d tc=%b want 8 0", c4, t4); end
    up_down = 1; step();
    n_checks++;
    if (c4 !== 4'd9 || t4 !== 1'b0 || m4 !== 1'b1) begin
      n_fail++; $display("FAIL dir_up1: count=%0d tc=%b max=%b want 9 0 1", c4, t4, m4);
    end
    step();
    n_checks++;
    if (c4 !== 4'd0 || t4 !== 1'b1) begin n_fail++; $display("FAIL dir_wrap: count=%0d tc=%b want 0 1", c4, t4); end
    enable = 0; step();
    n_checks++;
    if (c4 !== 4'd0 || t4 !== 1'b0 || o4 !== 1'b1) begin
      n_fail++; $display("FAIL pulse_drop: count=%0d tc=%b ovf=%b want 0 0 1", c4, t4, o4);
    end
    $display("test_direction done");
  endtask

  task automatic test_full_range();
    idle(); reset = 1; step(); idle();
    enable = 1; up_down = 0; saturate = 0; step();
    n_checks++;
    if (c8 !== 8'd255 || t8 !== 1'b1 || o8 !== 1'b1 || m8 !== 1'b1) begin
      n_fail++; $display("FAIL full_wrap: count=%0d tc=%b ovf=%b max=%b want 255 1 1 1", c8, t8, o8, m8);
    end
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (c8 !== 8'd255 || t8 !== 1'b0) begin
        n_fail++; $display("FAIL full_hold[%0d]: count=%0d tc=%b want 255 0", i, c8, t8);
      end
    end
    $display("test_full_range done");
  endtask

  task automatic test_max1();
    logic exp_c;
    idle(); reset = 1; step(); idle();
    enable = 1; up_down = 1; saturate = 0;
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0);
      step();
      n_checks++;
      if (c1 !== exp_c || t1 !== ~exp_c || m1 !== exp_c || z1 !== ~exp_c) begin
        n_fail++; $display("FAIL max1[%0d]: count=%0d tc=%b max=%b zero=%b want %0d %b", i, c1, t1, m1, z1, exp_c, ~exp_c);
      end
    end
    $display("test_max1 done");
  endtask

  initial begin
    idle();
    test_reset();
    test_up_wrap();
    test_down_saturate();
    test_load_clamp();
    test_direction();
    test_full_range();
    test_max1();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
